// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: register map,
// route field encoding and the CPU interrupt line count.
// No logic state; a helper decides whether a route code selects a line.
package int_ctrl_pkg;

    // Word addresses of the software register port
    localparam logic [2:0] INTC_RAW   = 3'd0;
    localparam logic [2:0] INTC_PEND  = 3'd1;
    localparam logic [2:0] INTC_MASK  = 3'd2;
    localparam logic [2:0] INTC_MODE  = 3'd3;
    localparam logic [2:0] INTC_POL   = 3'd4;
    localparam logic [2:0] INTC_ROUTE = 3'd5;
    localparam logic [2:0] INTC_SWSET = 3'd6;
    localparam logic [2:0] INTC_RSVD  = 3'd7;

    localparam int ROUTE_W = 3;

    // Route codes that disconnect a source from every CPU line
    localparam logic [ROUTE_W-1:0] ROUTE_DIS_A = 3'd6;
    localparam logic [ROUTE_W-1:0] ROUTE_DIS_B = 3'd7;

    localparam int NUM_INT_LINES = 6;

    function automatic logic route_enabled(input logic [ROUTE_W-1:0] code);
        return !((code == ROUTE_DIS_A) || (code == ROUTE_DIS_B));
    endfunction

endpackage

// File: rtl/int_src_cond.sv
// Per-source conditioning: synchroniser, polarity, level/edge pending latch.
// Latency: SYNC_STAGES clocks to s, one more to pend_o.
// Backpressure: none; pending in edge mode holds until software W1C.
// Ports: irq_i async request; pol_i/mode_i config; suppress_i blocks edge
//        detection; w1c_i/swset_i software clear/set; raw_o = s; pend_o.
module int_src_cond
    import int_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic pol_i,
    input  logic mode_i,
    input  logic suppress_i,
    input  logic w1c_i,
    input  logic swset_i,
    output logic raw_o,
    output logic pend_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pend_q;
    logic                   pend_d;
    logic                   act;
    logic                   edge_det;

    assign raw_o    = sync_q[SYNC_STAGES-1];
    assign act      = raw_o ^ pol_i;
    // prev keeps tracking act while suppressed, so a config change never
    // leaves a stale low level behind that would look like an edge later.
    assign edge_det = act & ~prev_q & ~suppress_i;

    always_comb begin
        pend_d = pend_q;
        if (!mode_i) begin
            pend_d = act;
        end else if (edge_det || swset_i) begin
            pend_d = 1'b1;           // set beats a simultaneous W1C
        end else if (w1c_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prev_q <= act;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/int_ctrl.sv
// External interrupt controller: conditions NUM_SRC requests, masks and
// routes them onto the six CPU interrupt lines, merges the core timer.
// Latency: source to int_o SYNC_STAGES+2 clocks; timer to int_o[5] 1 clock.
// Backpressure: none; register reads return data the cycle after re_i.
// Ports: irq_src_i requests, timer_int_i, we_i/re_i/addr_i/wdata_i/rdata_o
//        register port, int_o to the CPU.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC-1:0]       irq_src_i,
    input  logic                     timer_int_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [2:0]               addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic [NUM_INT_LINES-1:0] int_o
);

    logic [NUM_SRC-1:0]         mask_q;
    logic [NUM_SRC-1:0]         mode_q;
    logic [NUM_SRC-1:0]         pol_q;
    logic [ROUTE_W*NUM_SRC-1:0] route_q;
    logic                       suppress_q;
    logic [NUM_INT_LINES-1:0]   int_q;
    logic [NUM_INT_LINES-1:0]   int_d;
    logic [31:0]                rdata_q;
    logic [31:0]                rdata_d;
    logic [NUM_SRC-1:0]         raw;
    logic [NUM_SRC-1:0]         pend;
    logic                       wr_pend;
    logic                       wr_swset;
    logic                       unused_wdata;

    assign wr_pend      = we_i && (addr_i == INTC_PEND);
    assign wr_swset     = we_i && (addr_i == INTC_SWSET);
    assign unused_wdata = ^wdata_i[31:ROUTE_W*NUM_SRC];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        int_src_cond #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_src (
            .clk        (clk),
            .rst        (rst),
            .irq_i      (irq_src_i[k]),
            .pol_i      (pol_q[k]),
            .mode_i     (mode_q[k]),
            .suppress_i (suppress_q),
            .w1c_i      (wr_pend && wdata_i[k]),
            .swset_i    (wr_swset && wdata_i[k]),
            .raw_o      (raw[k]),
            .pend_o     (pend[k])
        );
    end

    always_comb begin
        int_d = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pend[k] && mask_q[k] && route_enabled(route_q[ROUTE_W*k +: ROUTE_W])) begin
                int_d[route_q[ROUTE_W*k +: ROUTE_W]] = 1'b1;
            end
        end
        int_d[NUM_INT_LINES-1] = int_d[NUM_INT_LINES-1] | timer_int_i;
    end

    // Read mux sees register state before any same-cycle write lands.
    always_comb begin
        rdata_d = '0;
        case (addr_i)
            INTC_RAW:   rdata_d[NUM_SRC-1:0]         = raw;
            INTC_PEND:  rdata_d[NUM_SRC-1:0]         = pend;
            INTC_MASK:  rdata_d[NUM_SRC-1:0]         = mask_q;
            INTC_MODE:  rdata_d[NUM_SRC-1:0]         = mode_q;
            INTC_POL:   rdata_d[NUM_SRC-1:0]         = pol_q;
            INTC_ROUTE: rdata_d[ROUTE_W*NUM_SRC-1:0] = route_q;
            INTC_SWSET, INTC_RSVD: rdata_d = '0;
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q     <= '0;
            mode_q     <= '0;
            pol_q      <= '0;
            route_q    <= '0;
            suppress_q <= 1'b0;
            int_q      <= '0;
            rdata_q    <= '0;
        end else begin
            int_q      <= int_d;
            // New MODE/POL changes act combinationally; mask the edge
            // detector for the one cycle where prev still holds the old act.
            suppress_q <= we_i && ((addr_i == INTC_MODE) || (addr_i == INTC_POL));
            if (re_i) begin
                rdata_q <= rdata_d;
            end
            if (we_i) begin
                case (addr_i)
                    INTC_MASK:  mask_q  <= wdata_i[NUM_SRC-1:0];
                    INTC_MODE:  mode_q  <= wdata_i[NUM_SRC-1:0];
                    INTC_POL:   pol_q   <= wdata_i[NUM_SRC-1:0];
                    INTC_ROUTE: route_q <= wdata_i[ROUTE_W*NUM_SRC-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign int_o   = int_q;
    assign rdata_o = rdata_q;

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- External interrupt controller that drives the CPU core's 6-bit hardware interrupt input (`int_i`). It accepts the core's `timer_int_o` back.
- Collects NUM_SRC asynchronous peripheral interrupt requests. Each request is synchronised, conditioned (polarity, level or edge) and latched as pending.
- Masked and routed pending requests are OR-reduced onto the six CPU interrupt lines.
- Software configures and acknowledges through a simple word-addressed register port.

Parameters:
- NUM_SRC, 8, number of peripheral interrupt sources (1..8).
- SYNC_STAGES, 2, synchroniser depth on each source input (>=2).

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous reset, active-low.
- irq_src_i  input  NUM_SRC  asynchronous peripheral requests.
- timer_int_i  input  1  core timer interrupt (from `timer_int_o`); synchronous to clk.
- we_i  input  1  register write strobe.
- re_i  input  1  register read strobe.
- addr_i  input  3  register word address.
- wdata_i  input  32  write data.
- rdata_o  output  32  read data; valid the cycle after re_i.
- int_o  output  6  to CPU `int_i`; registered.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0. All internal registers and synchroniser flops 0.
  - Reset values: MASK=0 (all masked), MODE=0 (level), POL=0 (active-high), ROUTE=0.
  - Reset mid-operation discards all pending state immediately.
- Synchroniser: each irq_src_i[k] passes through SYNC_STAGES flops, giving s[k].
- Active level: act[k] = s[k] XOR POL[k].
- Previous-level flop: prev[k] <= act[k] every cycle.
- Pending, level mode (MODE[k]=0):
  - PEND[k] <= act[k] each cycle; not latched.
  - W1C and SWSET have no effect.
- Pending, edge mode (MODE[k]=1):
  - PEND[k] is set when act[k] & ~prev[k], or when SWSET bit k is written.
  - PEND[k] is cleared by writing 1 to PEND bit k.
  - Set and clear in the same cycle: set wins.
- Edge suppression: in the cycle a write to MODE or POL takes effect, edge detection is suppressed for all sources. prev still updates, so no spurious edge appears.
- Routing: ROUTE[3k+2:3k] selects the int_o line for source k.
  - Values 0..5 select that line.
  - Values 6..7 disable the source.
- Output: int_o[n] <= OR over k of (PEND[k] & MASK[k] & route==n). Additionally, int_o[5] is ORed with timer_int_i registered once.
- Latency, default SYNC_STAGES=2: irq_src_i rising at clock edge 0 gives PEND at edge 3 and int_o at edge 4.
  - Generally the source-to-int_o latency is SYNC_STAGES+2.
  - timer_int_i to int_o[5] is 1 cycle.
- Register map (word addresses; bits above NUM_SRC read 0 and ignore writes):
  - 0 RAW (RO, s[]).
  - 1 PEND (R, W1C).
  - 2 MASK (RW).
  - 3 MODE (RW).
  - 4 POL (RW).
  - 5 ROUTE (RW, bits 3*NUM_SRC-1:0).
  - 6 SWSET (WO, reads 0).
  - 7 reserved (reads 0, writes ignored).
- Reads:
  - rdata_o is registered. It is updated only on cycles with re_i and holds its value otherwise.
  - When we_i and re_i target the same address in the same cycle, the read returns the pre-write value.
- Writes take effect at the clock edge where we_i is sampled high.

Decomposition:
- Shared package / defines header:
  - register address constants (INTC_RAW..INTC_SWSET);
  - ROUTE field width 3;
  - route disable codes 6 and 7;
  - the CPU interrupt line count, 6.
- One sub-module, int_src_cond. It is instantiated per source and contains:
  - synchroniser;
  - polarity;
  - prev flop;
  - edge/level pending logic with W1C/SWSET inputs and the suppress input.
- The top level holds the config registers, the routing OR-reduction, the timer merge and the read mux.

Test Plan:
- Reset then read addresses 0..7:
  - every rdata_o is 0x0 and int_o stays 6'b0;
  - assert rst low mid-pending: PEND and int_o drop to 0 asynchronously, without waiting for clk.
- Level source 2, route 3, MASK=0x04:
  - raise irq_src_i[2] at cycle 0: int_o = 6'b001000 at cycle 4;
  - drop it: int_o returns to 0 four cycles later;
  - W1C write to PEND is ignored.
- Edge source 0, MODE=0x01, MASK=0x01, route 0:
  - 1-cycle pulse on irq_src_i[0]: PEND=0x01 and int_o[0]=1 held;
  - write PEND=0x01: int_o[0]=0 one cycle later.
- Edge source 0, simultaneous edge and W1C in the same cycle: PEND bit 0 stays 1 (set wins).
- POL=0x01 on level source 0 with input low: int_o[0]=1.
  - Write POL=0x01 while in edge mode with the input high: no spurious PEND set.
- Timer and routing:
  - timer_int_i=1: int_o[5]=1 one cycle later, regardless of MASK;
  - source route code 6: never asserts any int_o bit;
  - SWSET=0x80 with MODE bit 7 set: PEND=0x80.
